// File: rtl/uart_pkg.sv
// Shared UART receiver definitions: FSM state encoding and oversampling
// constants. The tick counter is 4 bits wide, so the tick constants are
// declared at that width.
package uart_pkg;

  typedef enum logic [2:0] {
    idle   = 3'd0,
    start  = 3'd1,
    data   = 3'd2,
    parity = 3'd3,
    stop   = 3'd4
  } state_t;

  localparam int         OVERSAMPLE = 16;
  localparam logic [3:0] MID_TICK   = 4'd7;
  localparam logic [3:0] LAST_TICK  = 4'd15;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous rx line. Both flops reset to 1,
// which is the idle level of the line, so reset never fakes a start edge.
module uart_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // Two-stage capture of the asynchronous input, set to idle-high on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// UART receiver: start bit, data_size data bits LSB-first, optional even
// parity bit, one stop bit, using a 16x oversampling tick.
// Optional feature macro: UART_RX_PARITY_EN adds the parity state and the
// parity_err output.
//
// Output handshake: no back-pressure. rx_done_tick is a one-cycle strobe in
// the cycle rx_dout takes its new value; frame_err / parity_err are one-cycle
// strobes for rejected frames, during which rx_dout keeps its old value.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int data_size = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 s_tick,
  input  logic                 rx,
  output logic [data_size-1:0] rx_dout,
  output logic                 rx_done_tick,
  output logic                 frame_err,
`ifdef UART_RX_PARITY_EN
  output logic                 parity_err,
`endif
  output state_t               state_dbg
);

  localparam int             BW       = $clog2(data_size + 1);
  localparam logic [BW-1:0]  LAST_BIT = BW'(data_size - 1);

  logic                 rx_s;
  state_t               state_q, state_n;
  logic [3:0]           tick_q, tick_n;
  logic [BW-1:0]        bit_q, bit_n;
  logic [data_size-1:0] shreg_q, shreg_n;
  logic [data_size-1:0] dout_n;
  logic                 done_n;
  logic                 ferr_n;
`ifdef UART_RX_PARITY_EN
  logic                 perr_n;
  logic                 pflag_q, pflag_n;
`endif

  uart_rx_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx),
    .q     (rx_s)
  );

  assign state_dbg = state_q;

  // State, counters, shift register and registered output strobes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= idle;
      tick_q       <= '0;
      bit_q        <= '0;
      shreg_q      <= '0;
      rx_dout      <= '0;
      rx_done_tick <= 1'b0;
      frame_err    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err   <= 1'b0;
      pflag_q      <= 1'b0;
`endif
    end else begin
      state_q      <= state_n;
      tick_q       <= tick_n;
      bit_q        <= bit_n;
      shreg_q      <= shreg_n;
      rx_dout      <= dout_n;
      rx_done_tick <= done_n;
      frame_err    <= ferr_n;
`ifdef UART_RX_PARITY_EN
      parity_err   <= perr_n;
      pflag_q      <= pflag_n;
`endif
    end
  end

  // Next-state and datapath decisions; everything advances only on s_tick.
  always_comb begin
    state_n = state_q;
    tick_n  = tick_q;
    bit_n   = bit_q;
    shreg_n = shreg_q;
    dout_n  = rx_dout;
    done_n  = 1'b0;
    ferr_n  = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_n  = 1'b0;
    pflag_n = pflag_q;
`endif
    case (state_q)
      idle: begin
        tick_n = '0;
        bit_n  = '0;
`ifdef UART_RX_PARITY_EN
        pflag_n = 1'b0;
`endif
        if (!rx_s) state_n = start;
      end
      start: begin
        if (s_tick) begin
          if (tick_q == MID_TICK) begin
            // Mid start bit: a high line here was only a glitch.
            tick_n  = '0;
            state_n = rx_s ? idle : data;
          end else begin
            tick_n = tick_q + 4'd1;
          end
        end
      end
      data: begin
        if (s_tick) begin
          if (tick_q == LAST_TICK) begin
            shreg_n = {rx_s, shreg_q[data_size-1:1]};
            tick_n  = '0;
            bit_n   = bit_q + 1'b1;
            if (bit_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
              state_n = parity;
`else
              state_n = stop;
`endif
            end
          end else begin
            tick_n = tick_q + 4'd1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      parity: begin
        if (s_tick) begin
          if (tick_q == LAST_TICK) begin
            // Even parity: the parity bit must equal the XOR of the data.
            tick_n  = '0;
            pflag_n = (rx_s != (^shreg_q));
            state_n = stop;
          end else begin
            tick_n = tick_q + 4'd1;
          end
        end
      end
`endif
      stop: begin
        if (s_tick) begin
          if (tick_q == LAST_TICK) begin
            tick_n  = '0;
            state_n = idle;
            ferr_n  = !rx_s;
`ifdef UART_RX_PARITY_EN
            perr_n  = pflag_q;
            if (rx_s && !pflag_q) begin
              dout_n = shreg_q;
              done_n = 1'b1;
            end
`else
            if (rx_s) begin
              dout_n = shreg_q;
              done_n = 1'b1;
            end
`endif
          end else begin
            tick_n = tick_q + 4'd1;
          end
        end
      end
      default: begin
        state_n = idle;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver. s_tick pulses every 4 clk cycles, so a
// bit period is 64 clk cycles. Expected output events are queued by the
// stimulus and consumed by an independent monitor.
module tb_uart_receiver;
  import uart_pkg::*;

  localparam int W        = 8;
  localparam int EW       = W + 3;
  localparam int BIT_CLKS = 64;

  logic         clk    = 1'b0;
  logic         reset  = 1'b1;
  logic         s_tick = 1'b0;
  logic         rx     = 1'b1;
  logic [W-1:0] rx_dout;
  logic         rx_done_tick;
  logic         frame_err;
  logic         parity_err_w;
  state_t       state_dbg;

  int checks = 0;
  int errors = 0;

  // Event word: {frame_err, parity_err, rx_done_tick, rx_dout}
  logic [EW-1:0] exp_q[$];
  logic          prev_pulse = 1'b0;
  logic          corrupt_par = 1'b0;

  uart_receiver #(.data_size(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .s_tick       (s_tick),
    .rx           (rx),
    .rx_dout      (rx_dout),
    .rx_done_tick (rx_done_tick),
    .frame_err    (frame_err),
`ifdef UART_RX_PARITY_EN
    .parity_err   (parity_err_w),
`endif
    .state_dbg    (state_dbg)
  );

`ifndef UART_RX_PARITY_EN
  assign parity_err_w = 1'b0;
`endif

  // Clock and oversampling tick.
  always #5 clk = ~clk;

  initial begin
    forever begin
      repeat (3) @(negedge clk);
      s_tick = 1'b1;
      @(negedge clk);
      s_tick = 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, want);
    end
  endtask

  task automatic expect_evt(input logic ferr, input logic perr, input logic done,
                            input logic [W-1:0] dout);
    exp_q.push_back({ferr, perr, done, dout});
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  // Full frame. A low stop bit is held long enough to be sampled, then the
  // line returns high so the break does not become a new frame.
  task automatic send_frame(input logic [W-1:0] d, input logic stop_low);
    send_bit(1'b0);
    for (int i = 0; i < W; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit((^d) ^ corrupt_par);
`endif
    if (stop_low) begin
      rx = 1'b0;
      repeat (48) @(negedge clk);
      rx = 1'b1;
      repeat (16) @(negedge clk);
    end else begin
      send_bit(1'b1);
    end
  endtask

  // Monitor: every output strobe must match the next queued event and last
  // exactly one cycle.
  always @(negedge clk) begin
    logic          pulse;
    logic [EW-1:0] got;
    logic [EW-1:0] want;
    if (!reset) begin
      pulse = rx_done_tick | frame_err | parity_err_w;
      if (pulse) begin
        checks++;
        if (prev_pulse) begin
          errors++;
          $display("FAIL pulse_width: strobe high for more than one cycle");
        end
        got = {frame_err, parity_err_w, rx_done_tick, rx_dout};
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event: got 0x%0h with no event expected", got);
        end else begin
          want = exp_q.pop_front();
          if (got !== want) begin
            errors++;
            $display("FAIL event: got 0x%0h expected 0x%0h", got, want);
          end
        end
      end
      prev_pulse = pulse;
    end else begin
      prev_pulse = 1'b0;
    end
  end

  initial begin
    logic [W-1:0] aborted;
    int           waited;
    aborted = 8'h55;

    // Reset state.
    repeat (5) @(negedge clk);
    check("reset_dout", 32'(rx_dout), 32'h0);
    check("reset_done", 32'(rx_done_tick), 32'h0);
    check("reset_ferr", 32'(frame_err), 32'h0);
    check("reset_state", 32'(state_dbg), 32'(idle));
    reset = 1'b0;
    repeat (10) @(negedge clk);

    // Single good byte.
    expect_evt(1'b0, 1'b0, 1'b1, 8'hA5);
    send_frame(8'hA5, 1'b0);
    send_bit(1'b1);

    // Back-to-back frames with no idle gap.
    expect_evt(1'b0, 1'b0, 1'b1, 8'h00);
    expect_evt(1'b0, 1'b0, 1'b1, 8'hFF);
    send_frame(8'h00, 1'b0);
    send_frame(8'hFF, 1'b0);
    send_bit(1'b1);

    // Short low glitch: rejected at mid start bit.
    rx = 1'b0;
    repeat (12) @(negedge clk);
    rx = 1'b1;
    repeat (2 * BIT_CLKS) @(negedge clk);
    check("glitch_dout", 32'(rx_dout), 32'hFF);
    check("glitch_state", 32'(state_dbg), 32'(idle));

    // Low stop bit: frame error, output word unchanged.
    expect_evt(1'b1, 1'b0, 1'b0, 8'hFF);
    send_frame(8'h3C, 1'b1);
    send_bit(1'b1);
    check("ferr_dout", 32'(rx_dout), 32'hFF);

    // Reset during data bit 4 of 0x55, then a clean 0x81.
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(aborted[i]);
    rx = aborted[4];
    repeat (20) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("midreset_dout", 32'(rx_dout), 32'h0);
    check("midreset_state", 32'(state_dbg), 32'(idle));
    reset = 1'b0;
    rx = 1'b1;
    repeat (2 * BIT_CLKS) @(negedge clk);
    check("aborted_no_update", 32'(rx_dout), 32'h0);
    expect_evt(1'b0, 1'b0, 1'b1, 8'h81);
    send_frame(8'h81, 1'b0);
    send_bit(1'b1);
    check("after_abort_dout", 32'(rx_dout), 32'h81);

`ifdef UART_RX_PARITY_EN
    // Wrong parity bit on 0x07: parity error, output word unchanged.
    corrupt_par = 1'b1;
    expect_evt(1'b0, 1'b1, 1'b0, 8'h81);
    send_frame(8'h07, 1'b0);
    corrupt_par = 1'b0;
    send_bit(1'b1);
    check("perr_dout", 32'(rx_dout), 32'h81);
`endif

    // Every expected event must have been seen.
    waited = 0;
    while (exp_q.size() != 0 && waited < 1000) begin
      @(negedge clk);
      waited++;
    end
    check("events_outstanding", 32'(exp_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
